traffic_lights_cmd_seq: RTL

Command sequencer that sits directly upstream of the traffic-light controller and drives its cmd_type/cmd_valid/cmd_data inputs. It accepts host requests over a valid/ready interface and buffers them in a small FIFO. Forwarded commands are issued as single-cycle pulses, separated by a guaranteed idle gap. An optional auto mode generates the 3 -> 4 -> 5 (green, yellow, red) command cycle periodically, so the controller runs unattended.

---
 rtl/traffic_lights_cmd_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/traffic_lights_cmd_seq.sv
// ---------------------------------------------------------------------------
// TrafficLightsCmdSeq : command sequencer feeding the traffic-light controller
//
// Host requests arrive over a valid/ready handshake and are buffered in a
// small FIFO. Request types 0-5 are forwarded to the controller as one-cycle
// cmd_valid_o pulses. Type 6 (AUTO_ON) and type 7 (AUTO_OFF) only steer the
// built-in auto mode, which cycles green/yellow/red (3 -> 4 -> 5) on a
// programmable period. Consecutive pulses are always separated by at least
// GAP_CYCLES idle cycles.
//
// Ports
//   clk_i        clock
//   arst_i       asynchronous reset, active-high
//   req_valid_i  host request valid
//   req_ready_o  FIFO can accept a request (not full)
//   req_type_i   0-5 forwarded, 6 AUTO_ON, 7 AUTO_OFF
//   req_data_i   duration to forward, or auto period for AUTO_ON
//   cmd_type_o   command type to the controller
//   cmd_valid_o  one-cycle command strobe
//   cmd_data_o   command data, held between issues
//   auto_on_o    auto mode active
//   fifo_cnt_o   current FIFO occupancy
// ---------------------------------------------------------------------------
module traffic_lights_cmd_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2,
   parameter int AUTO_W     = 16
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [2:0]                    req_type_i,
   input  logic [15:0]                   req_data_i,
   output logic [2:0]                    cmd_type_o,
   output logic                          cmd_valid_o,
   output logic [15:0]                   cmd_data_o,
   output logic                          auto_on_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      GAP
   } state_t;

   // FIFO storage and bookkeeping
   logic [2:0]    fifoType_q [FIFO_DEPTH];
   logic [15:0]   fifoData_q [FIFO_DEPTH];
   logic [PW-1:0] wrPtr_q;
   logic [PW-1:0] rdPtr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Sequencer state and registered outputs
   state_t        state_q;
   logic [GW-1:0] gapCnt_q;
   logic [2:0]    cmdType_q;
   logic          cmdValid_q;
   logic [15:0]   cmdData_q;

   // Auto-mode state
   logic              autoOn_q;
   logic              autoPend_q;
   logic [1:0]        autoPhase_q;
   logic [AUTO_W-1:0] autoCnt_q;
   logic [AUTO_W-1:0] autoPeriod_q;

   logic          push;
   logic          pop;
   logic [2:0]    headType;
   logic [15:0]   headData;
   logic          autoExpire;
   logic [AUTO_W-1:0] newPeriod;

   // Ready depends only on the registered count so the host never sees a
   // combinational path from its own valid. A pop only happens in IDLE, so
   // a full FIFO refuses a push even in the cycle it is being drained.
   assign req_ready_o = (cnt_q < CW'(FIFO_DEPTH));
   assign push        = req_valid_i && req_ready_o;
   assign pop         = (state_q == IDLE) && (cnt_q != '0);
   assign headType    = fifoType_q[rdPtr_q];
   assign headData    = fifoData_q[rdPtr_q];

   // The auto counter expires on the cycle it holds period-1; a zero period
   // is coerced to 1 when it is loaded, so period-1 never underflows.
   assign autoExpire  = autoOn_q && (autoCnt_q == (autoPeriod_q - AUTO_W'(1)));
   assign newPeriod   = (AUTO_W'(headData) == '0) ? AUTO_W'(1) : AUTO_W'(headData);

   assign cmd_type_o  = cmdType_q;
   assign cmd_valid_o = cmdValid_q;
   assign cmd_data_o  = cmdData_q;
   assign auto_on_o   = autoOn_q;
   assign fifo_cnt_o  = cnt_q;

   // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // FIFO payload storage. Emptying on reset is done through the pointers and
   // count, so the storage itself needs no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifoType_q[wrPtr_q] <= req_type_i;
         fifoData_q[wrPtr_q] <= req_data_i;
      end
   end

   // FIFO pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
      end
   end

   // Main sequencer. The auto counter free-runs in every state while auto mode
   // is on; later assignments in the state decode deliberately override it
   // (AUTO_ON reload, resync on host types 0-2). Host entries always win over
   // a pending auto expiry, which simply waits for the next free IDLE cycle.
   // When an auto command is issued in the same cycle the counter expires
   // again, the fresh expiry is kept pending rather than lost.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= IDLE;
         gapCnt_q     <= '0;
         cmdType_q    <= '0;
         cmdValid_q   <= 1'b0;
         cmdData_q    <= '0;
         autoOn_q     <= 1'b0;
         autoPend_q   <= 1'b0;
         autoPhase_q  <= '0;
         autoCnt_q    <= '0;
         autoPeriod_q <= '0;
      end else begin
         cmdValid_q <= 1'b0;

         if (autoOn_q) begin
            if (autoExpire) begin
               autoCnt_q  <= '0;
               autoPend_q <= 1'b1;
            end else begin
               autoCnt_q <= autoCnt_q + AUTO_W'(1);
            end
         end

         case (state_q)
            IDLE: begin
               if (pop) begin
                  if (headType <= 3'd5) begin
                     cmdValid_q <= 1'b1;
                     cmdType_q  <= headType;
                     cmdData_q  <= headData;
                     state_q    <= ISSUE;
                     if (headType <= 3'd2) begin
                        autoCnt_q   <= '0;
                        autoPhase_q <= '0;
                     end
                  end else if (headType == 3'd6) begin
                     autoOn_q     <= 1'b1;
                     autoPeriod_q <= newPeriod;
                     autoCnt_q    <= '0;
                     autoPhase_q  <= '0;
                     autoPend_q   <= 1'b0;
                  end else begin
                     autoOn_q   <= 1'b0;
                     autoPend_q <= 1'b0;
                  end
               end else if (autoOn_q && autoPend_q) begin
                  cmdValid_q  <= 1'b1;
                  cmdType_q   <= 3'd3 + {1'b0, autoPhase_q};
                  state_q     <= ISSUE;
                  autoPhase_q <= (autoPhase_q == 2'd2) ? 2'd0 : autoPhase_q + 2'd1;
                  autoPend_q  <= autoExpire;
               end
            end
            ISSUE: begin
               gapCnt_q <= '0;
               state_q  <= GAP;
            end
            GAP: begin
               if (gapCnt_q == GW'(GAP_CYCLES - 1)) begin
                  state_q <= IDLE;
               end else begin
                  gapCnt_q <= gapCnt_q + GW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
